// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit -- iterative RV32M multiply/divide execution unit.
//
// Operands are taken as magnitudes at accept. The unit then runs 32 radix-2
// steps: shift-add for multiplies, restoring subtract-shift for divides. A
// final FIXUP cycle applies the signs and selects the result. Divide-by-zero
// and signed overflow (0x80000000 / -1) finish at the accept edge.
//
// Optional build macro:
//   MULDIV_ZERO_BYPASS_EN  multiplies with a zero operand finish at the accept
//                          edge with result 0, skipping the iterative path.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   flush             pipeline kill; returns to IDLE, overrides accept/completion
//   in_valid/in_ready request handshake (ready only in IDLE, low during rst)
//   funct3            RV32M op: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   rs1_data/rs2_data operand A / operand B
//   rd_addr           destination index, returned on rd_addr_out
//   out_valid/out_ready write-back handshake; out_valid is the RF write enable
//   result            write-back data, held while out_valid && !out_ready
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   a_q, a_d;        // |A|: multiplicand addend
  logic [XLEN-1:0]   b_q, b_d;        // |B|: divisor
  logic              sa_q, sa_d;      // A was negative and treated as signed
  logic              sb_q, sb_d;      // B was negative and treated as signed
  logic [2*XLEN-1:0] acc_q, acc_d;    // mul: {partial hi, multiplier}; div: {rem, quotient}
  logic [XLEN-1:0]   res_q, res_d;

  // Operand decode at the request boundary.
  logic            a_signed, b_signed, is_div, accept;
  logic            neg_a, neg_b, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  // One iteration step and the final sign fix.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   quo, rem;

  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign out_valid   = (state_q == S_DONE);
  assign result      = res_q;
  assign rd_addr_out = rd_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // one unassigned, which would infer a latch.
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    is_div   = funct3[2];
    neg_a    = a_signed && rs1_data[XLEN-1];
    neg_b    = b_signed && rs2_data[XLEN-1];
    a_mag    = neg_a ? -rs1_data : rs1_data;
    b_mag    = neg_b ? -rs2_data : rs2_data;
    // Accept is suppressed by flush so an ignored request leaves no trace.
    accept   = in_valid && (state_q == S_IDLE) && !flush;

    fast     = 1'b0;
    fast_res = '0;
    if (is_div && (rs2_data == '0)) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? rs1_data : ALL_ONES;
    end else if (is_div && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONES)) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? '0 : MIN_NEG;
    end
`ifdef MULDIV_ZERO_BYPASS_EN
    else if (!is_div && ((rs1_data == '0) || (rs2_data == '0))) begin
      fast     = 1'b1;
      fast_res = '0;
    end
`endif

    // Shift-add: add |A| to the high half when the multiplier LSB is set, then
    // shift the whole accumulator right, carry included.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: the shifted partial remainder is < 2*|B|, so 33 bits
    // hold it and the difference always fits back in XLEN bits.
    div_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, b_q};
    div_next = (div_sh >= {1'b0, b_q}) ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                       : {div_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0};

    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = funct3;
          rd_d  = rd_addr;
          a_d   = a_mag;
          b_d   = b_mag;
          sa_d  = neg_a;
          sb_d  = neg_b;
          cnt_d = '0;
          acc_d = is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          if (fast) begin
            res_d   = fast_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {CNT_W{1'b1}}) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        unique case ({op_q[2], op_q[1:0] == 2'b00, op_q[1]})
          3'b010, 3'b011: res_d = prod[XLEN-1:0];
          3'b000, 3'b001: res_d = prod[2*XLEN-1:XLEN];
          3'b100, 3'b110: res_d = quo;
          default:        res_d = rem;
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: every register, including the datapath, is cleared by reset so the
    // outputs read 0 after reset and no stale operation can resurface.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit -- directed self-checking bench for muldiv_unit.
// Inputs are driven just after the rising edge; outputs are sampled on the
// falling edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, result;
  logic [4:0]  rd_addr, rd_addr_out;

  int n_vec = 0;
  int n_err = 0;

`ifdef MULDIV_ZERO_BYPASS_EN
  localparam int ZERO_MUL_LAT = 0;
`else
  localparam int ZERO_MUL_LAT = 33;
`endif

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .funct3      (funct3),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rd_addr     (rd_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .rd_addr_out (rd_addr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op; exp_lat counts edges after the accept edge until out_valid
  // (33 iterative, 0 fast path). hold > 0 keeps out_ready low that many cycles.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input int hold);
    int          lat;
    bit          busy_ok, stable;
    logic [31:0] r0;
    @(negedge clk);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    funct3    = f;
    rs1_data  = a;
    rs2_data  = b;
    rd_addr   = rd;
    out_ready = (hold == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rs1_data = 32'h0;
    rs2_data = 32'h0;
    rd_addr  = 5'd0;
    lat      = 0;
    busy_ok  = 1'b1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " rd_addr_out"}, {27'd0, rd_addr_out}, {27'd0, rd});
    check({tag, " in_ready low while busy"}, {31'd0, busy_ok}, 32'd1);
    if (hold > 0) begin
      stable = 1'b1;
      r0     = result;
      repeat (hold) begin
        @(negedge clk);
        if (!out_valid || in_ready || result !== r0 || rd_addr_out !== rd) stable = 1'b0;
      end
      check({tag, " held stable"}, {31'd0, stable}, 32'd1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, " released"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  // Start a MUL, then kill it with flush or rst while the counter equals at_cnt.
  task automatic abort_run(input string tag, input bit use_rst, input int at_cnt);
    int seen;
    @(negedge clk);
    in_valid  = 1'b1;
    funct3    = 3'b000;
    rs1_data  = 32'd9;
    rs2_data  = 32'd9;
    rd_addr   = 5'd3;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (at_cnt) @(posedge clk);
    #1 if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check({tag, " in_ready after abort"}, {31'd0, in_ready}, 32'd1);
    if (use_rst) check({tag, " result cleared"}, result, 32'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check({tag, " no out_valid"}, seen, 0);
    run_op({tag, " MUL 3x4"}, 3'b000, 32'd3, 32'd4, 5'd7, 32'd12, 33, 0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    funct3    = 3'b000;
    rs1_data  = 32'h0;
    rs2_data  = 32'h0;
    rd_addr   = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'h0);
    check("reset rd_addr_out", {27'd0, rd_addr_out}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Multiplies.
    run_op("MUL 7*-3",     3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, 0);
    run_op("MULHU -1*-1",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33, 0);
    run_op("MULH -1*-1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'h00000000, 33, 0);
    run_op("MULHSU -1*u",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFF, 33, 0);

    // Divides.
    run_op("DIV -7/2",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33, 0);
    run_op("REM -7%2",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33, 0);
    run_op("DIVU 100/7",   3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       33, 0);
    run_op("REMU 100%7",   3'b111, 32'd100,      32'd7,        5'd0,  32'd2,        33, 0);

    // Fast paths: divide by zero and signed overflow.
    run_op("DIVU 5/0",     3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 0, 0);
    run_op("REM 5%0",      3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        0, 0);
    run_op("DIV ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 0, 0);
    run_op("REM ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 0, 0);

    // Back-pressure: result held for 5 cycles with out_ready low.
    run_op("DIVU hold",    3'b101, 32'd100,      32'd7,        5'd17, 32'd14,       33, 5);

    // flush together with in_valid in IDLE: request ignored.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    rs1_data = 32'd1;
    rs2_data = 32'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush+req ignored", {30'd0, out_valid, in_ready}, 32'b01);

    // Aborts mid-calculation.
    abort_run("flush@10", 1'b0, 10);
    abort_run("rst@20",   1'b1, 20);

    // Multiply by zero: bypassed when the option is built in.
    run_op("MUL 0*5",      3'b000, 32'd0,        32'd5,        5'd18, 32'd0, ZERO_MUL_LAT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
